// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction constants and the TAP next-state function
package jtag_pkg;
  typedef enum logic [3:0] {
    EX2DR   = 4'h0,
    EX1DR   = 4'h1,
    SHDR    = 4'h2,
    PAUSEDR = 4'h3,
    SELIR   = 4'h4,
    UPDDR   = 4'h5,
    CAPDR   = 4'h6,
    SELDR   = 4'h7,
    EX2IR   = 4'h8,
    EX1IR   = 4'h9,
    SHIR    = 4'hA,
    PAUSEIR = 4'hB,
    RTI     = 4'hC,
    UPDIR   = 4'hD,
    CAPIR   = 4'hE,
    TLR     = 4'hF
  } tap_state_t;
  localparam logic [31:0] IR_IDCODE = 32'd1;
  localparam logic [31:0] IR_BYPASS = '1;
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:     tap_next = tms ? TLR   : RTI;
      RTI:     tap_next = tms ? SELDR : RTI;
      SELDR:   tap_next = tms ? SELIR : CAPDR;
      CAPDR:   tap_next = tms ? EX1DR : SHDR;
      SHDR:    tap_next = tms ? EX1DR : SHDR;
      EX1DR:   tap_next = tms ? UPDDR : PAUSEDR;
      PAUSEDR: tap_next = tms ? EX2DR : PAUSEDR;
      EX2DR:   tap_next = tms ? UPDDR : SHDR;
      UPDDR:   tap_next = tms ? SELDR : RTI;
      SELIR:   tap_next = tms ? TLR   : CAPIR;
      CAPIR:   tap_next = tms ? EX1IR : SHIR;
      SHIR:    tap_next = tms ? EX1IR : SHIR;
      EX1IR:   tap_next = tms ? UPDIR : PAUSEIR;
      PAUSEIR: tap_next = tms ? EX2IR : PAUSEIR;
      EX2IR:   tap_next = tms ? UPDIR : SHIR;
      UPDIR:   tap_next = tms ? SELDR : RTI;
      default: tap_next = TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller advanced by the TCK rising-edge strobe
//   clock/reset : system clock, async active-high reset
//   i_step      : TCK rising-edge strobe
//   i_tms       : synchronized TMS aligned to the strobe
//   i_trst      : synchronized test reset, forces Test-Logic-Reset
//   o_state     : current TAP state
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_step,
  input  logic       i_tms,
  input  logic       i_trst,
  output logic [3:0] o_state
);
  tap_state_t r_state;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= TLR;
    else if (i_trst) r_state <= TLR;
    else if (i_step) r_state <= tap_next(r_state, i_tms);
  assign o_state = r_state;
endmodule

// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: JTAG TAP responder oversampling all pins in the system clock domain
//   clock/reset                 : system clock, async active-high reset
//   jtag_TCK/TMS/TDI/TRSTn      : host-driven JTAG pins, sampled as data
//   jtag_TDO_data/TDO_driven    : TDO value and its valid flag (Shift-IR / Shift-DR)
//   user_capture_value          : loaded into USER at Capture-DR
//   user_update_valid/bits      : one-cycle pulse with USER contents at Update-DR
//   ir_value, tap_state         : current instruction and TAP state
module jtag_tap_oversampled
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH      = 5,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h00000001,
  parameter int                  USER_DR_WIDTH = 32,
  parameter logic [IR_WIDTH-1:0] USER_INSTR    = 5'h10,
  parameter int                  SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     jtag_TCK,
  input  logic                     jtag_TMS,
  input  logic                     jtag_TDI,
  input  logic                     jtag_TRSTn,
  output logic                     jtag_TDO_data,
  output logic                     jtag_TDO_driven,
  input  logic [USER_DR_WIDTH-1:0] user_capture_value,
  output logic                     user_update_valid,
  output logic [USER_DR_WIDTH-1:0] user_update_bits,
  output logic [IR_WIDTH-1:0]      ir_value,
  output logic [3:0]               tap_state
);
  localparam logic [IR_WIDTH-1:0] IR_ID = IR_WIDTH'(IR_IDCODE);
  logic [SYNC_STAGES-1:0]   r_tck_s, r_tms_s, r_tdi_s, r_trstn_s;
  logic                     r_tck_prev;
  logic [IR_WIDTH-1:0]      r_ir, r_ir_sr;
  logic [31:0]              r_id_sr;
  logic [USER_DR_WIDTH-1:0] r_user_sr, r_upd_bits;
  logic                     r_bypass, r_tdo, r_tdo_drv, r_upd_valid;
  logic                     w_tck, w_tms, w_tdi, w_trst, w_rise, w_fall;
  logic                     w_sel_id, w_sel_user, w_tdo_next;
  logic [3:0]               w_state_bits;
  tap_state_t               w_state;
  // TMS/TDI take the same synchronizer depth as TCK so they stay aligned to its edges
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_tck_s    <= '0;
      r_tms_s    <= '1;
      r_tdi_s    <= '0;
      r_trstn_s  <= '1;
      r_tck_prev <= 1'b0;
    end else begin
      r_tck_s    <= {r_tck_s[SYNC_STAGES-2:0], jtag_TCK};
      r_tms_s    <= {r_tms_s[SYNC_STAGES-2:0], jtag_TMS};
      r_tdi_s    <= {r_tdi_s[SYNC_STAGES-2:0], jtag_TDI};
      r_trstn_s  <= {r_trstn_s[SYNC_STAGES-2:0], jtag_TRSTn};
      r_tck_prev <= r_tck_s[SYNC_STAGES-1];
    end
  assign w_tck  = r_tck_s[SYNC_STAGES-1];
  assign w_tms  = r_tms_s[SYNC_STAGES-1];
  assign w_tdi  = r_tdi_s[SYNC_STAGES-1];
  assign w_trst = ~r_trstn_s[SYNC_STAGES-1];
  assign w_rise = w_tck & ~r_tck_prev & ~w_trst;
  assign w_fall = ~w_tck & r_tck_prev & ~w_trst;
  jtag_tap_fsm u_fsm (
    .clock   (clock),
    .reset   (reset),
    .i_step  (w_rise),
    .i_tms   (w_tms),
    .i_trst  (w_trst),
    .o_state (w_state_bits)
  );
  assign w_state    = tap_state_t'(w_state_bits);
  assign w_sel_id   = r_ir == IR_ID;
  assign w_sel_user = (r_ir == USER_INSTR) & ~w_sel_id;
  assign w_tdo_next = (w_state == SHIR) ? r_ir_sr[0] :
                      w_sel_id          ? r_id_sr[0] :
                      w_sel_user        ? r_user_sr[0] : r_bypass;
  // Capture/update actions belong to the state being left on the rising strobe
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_ir        <= IR_ID;
      r_ir_sr     <= '0;
      r_id_sr     <= '0;
      r_user_sr   <= '0;
      r_bypass    <= 1'b0;
      r_tdo       <= 1'b0;
      r_tdo_drv   <= 1'b0;
      r_upd_valid <= 1'b0;
      r_upd_bits  <= '0;
    end else begin
      r_upd_valid <= 1'b0;
      if (w_trst) begin
        r_ir      <= IR_ID;
        r_tdo_drv <= 1'b0;
      end else begin
        if (w_state == TLR) r_ir <= IR_ID;
        if (w_rise)
          case (w_state)
            CAPIR: r_ir_sr <= IR_WIDTH'(1);
            SHIR:  r_ir_sr <= {w_tdi, r_ir_sr[IR_WIDTH-1:1]};
            UPDIR: r_ir <= r_ir_sr;
            CAPDR:
              if (w_sel_id) r_id_sr <= IDCODE_VALUE;
              else if (w_sel_user) r_user_sr <= user_capture_value;
              else r_bypass <= 1'b0;
            SHDR:
              if (w_sel_id) r_id_sr <= {w_tdi, r_id_sr[31:1]};
              else if (w_sel_user) r_user_sr <= {w_tdi, r_user_sr[USER_DR_WIDTH-1:1]};
              else r_bypass <= w_tdi;
            UPDDR:
              if (w_sel_user) begin
                r_upd_valid <= 1'b1;
                r_upd_bits  <= r_user_sr;
              end
            default: ;
          endcase
        if (w_fall) begin
          r_tdo     <= w_tdo_next;
          r_tdo_drv <= (w_state == SHIR) | (w_state == SHDR);
        end
      end
    end
  assign jtag_TDO_data     = r_tdo;
  assign jtag_TDO_driven   = r_tdo_drv;
  assign user_update_valid = r_upd_valid;
  assign user_update_bits  = r_upd_bits;
  assign ir_value          = r_ir;
  assign tap_state         = w_state_bits;
endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: scoreboard bench driving the TAP through directed host sequences
module tb_jtag_tap_oversampled;
  localparam logic [31:0] IDC = 32'h20000913;
  logic        clock = 0, reset = 1;
  logic        jtag_TCK = 0, jtag_TMS = 1, jtag_TDI = 0, jtag_TRSTn = 1;
  logic        jtag_TDO_data, jtag_TDO_driven, user_update_valid;
  logic [31:0] user_capture_value = 0, user_update_bits;
  logic [4:0]  ir_value;
  logic [3:0]  tap_state;
  typedef struct {
    int         tag;
    logic [3:0] st;
    logic [4:0] ir;
    logic       drv;
    logic       chk0;
  } stat_t;
  stat_t       st_q[$];
  logic        tdo_q[$];
  logic [31:0] upd_q[$];
  int          checks = 0, failures = 0;
  bit          done = 0;
  always #5 clock = ~clock;
  jtag_tap_oversampled #(
    .IR_WIDTH(5), .IDCODE_VALUE(IDC), .USER_DR_WIDTH(32), .USER_INSTR(5'h10), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
    .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn), .jtag_TDO_data(jtag_TDO_data),
    .jtag_TDO_driven(jtag_TDO_driven), .user_capture_value(user_capture_value),
    .user_update_valid(user_update_valid), .user_update_bits(user_update_bits),
    .ir_value(ir_value), .tap_state(tap_state)
  );
  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic tck(input logic tms, input logic tdi);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    clk(6);
    jtag_TCK = 1;
    clk(6);
    jtag_TCK = 0;
  endtask
  task automatic push_st(input int tag, input logic [3:0] s, input logic [4:0] ir, input logic drv, input logic c0);
    stat_t x;
    x.tag = tag; x.st = s; x.ir = ir; x.drv = drv; x.chk0 = c0;
    st_q.push_back(x);
  endtask
  task automatic status(input int tag, input logic [3:0] s, input logic [4:0] ir, input logic drv, input logic c0);
    clk(4);
    push_st(tag, s, ir, drv, c0);
    clk(2);
  endtask
  task automatic shift(input logic [31:0] din, input logic [31:0] dout, input int n, input logic last_tms);
    for (int i = 0; i < n; i++) begin
      tdo_q.push_back(dout[i]);
      tck((i == n - 1) && last_tms, din[i]);
    end
  endtask
  task automatic to_sdr;
    tck(1, 0); tck(0, 0); tck(0, 0);
  endtask
  task automatic to_sir;
    tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
  endtask
  task automatic finish_upd;
    tck(1, 0); tck(0, 0);
  endtask
  // monitor: TDO is checked where the host samples it (TCK pin rising while driven)
  initial begin
    logic        tck_q, e;
    logic [31:0] eu;
    stat_t       s;
    tck_q = 0;
    forever begin
      @(negedge clock);
      if (jtag_TCK && !tck_q && jtag_TDO_driven) begin
        checks++;
        if (tdo_q.size() == 0) begin
          failures++;
          $display("FAIL tdo_unexpected actual=%0b required=no_shift", jtag_TDO_data);
        end else begin
          e = tdo_q.pop_front();
          if (jtag_TDO_data !== e) begin
            failures++;
            $display("FAIL tdo actual=%0b required=%0b at %0t", jtag_TDO_data, e, $time);
          end
        end
      end
      tck_q = jtag_TCK;
      if (user_update_valid) begin
        checks++;
        if (upd_q.size() == 0) begin
          failures++;
          $display("FAIL upd_unexpected actual=%h required=no_pulse", user_update_bits);
        end else begin
          eu = upd_q.pop_front();
          if (user_update_bits !== eu) begin
            failures++;
            $display("FAIL upd_bits actual=%h required=%h", user_update_bits, eu);
          end
        end
      end
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        checks += 3;
        if (tap_state !== s.st) begin
          failures++;
          $display("FAIL status%0d state actual=%h required=%h", s.tag, tap_state, s.st);
        end
        if (ir_value !== s.ir) begin
          failures++;
          $display("FAIL status%0d ir actual=%h required=%h", s.tag, ir_value, s.ir);
        end
        if (jtag_TDO_driven !== s.drv) begin
          failures++;
          $display("FAIL status%0d driven actual=%0b required=%0b", s.tag, jtag_TDO_driven, s.drv);
        end
        if (s.chk0) begin
          checks++;
          if ({jtag_TDO_data, user_update_valid, user_update_bits} !== 34'd0) begin
            failures++;
            $display("FAIL status%0d zero_outputs actual=%0b/%0b/%h required=0/0/0", s.tag,
                     jtag_TDO_data, user_update_valid, user_update_bits);
          end
        end
      end
      if (done) begin
        checks += 2;
        if (tdo_q.size() != 0) begin
          failures++;
          $display("FAIL tdo_pending actual=%0d required=0", tdo_q.size());
        end
        if (upd_q.size() != 0) begin
          failures++;
          $display("FAIL upd_pending actual=%0d required=0", upd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end
  initial begin
    clk(3);
    reset = 0;
    status(0, 4'hF, 5'h01, 0, 1);
    tck(0, 0);
    status(1, 4'hC, 5'h01, 0, 0);
    to_sdr;
    status(2, 4'h2, 5'h01, 1, 0);
    shift(32'h0, IDC, 32, 1);
    status(3, 4'h1, 5'h01, 0, 0);
    finish_upd;
    status(4, 4'hC, 5'h01, 0, 0);
    to_sdr;
    tdo_q.push_back(1'b1);
    repeat (5) tck(1, 0);
    status(5, 4'hF, 5'h01, 0, 0);
    tck(0, 0);
    status(6, 4'hC, 5'h01, 0, 0);
    to_sir;
    shift(32'h1F, 32'h01, 5, 1);
    finish_upd;
    status(7, 4'hC, 5'h1F, 0, 0);
    to_sdr;
    shift(32'h0D, 32'h1A, 5, 1);
    finish_upd;
    status(8, 4'hC, 5'h1F, 0, 0);
    to_sir;
    shift(32'h10, 32'h01, 5, 1);
    finish_upd;
    status(9, 4'hC, 5'h10, 0, 0);
    user_capture_value = 32'h12345678;
    to_sdr;
    shift(32'hDEADBEEF, 32'h12345678, 32, 1);
    upd_q.push_back(32'hDEADBEEF);
    finish_upd;
    status(10, 4'hC, 5'h10, 0, 0);
    user_capture_value = 32'hA5A5A5A5;
    to_sdr;
    shift(32'h0, 32'hA5A5A5A5, 10, 0);
    jtag_TRSTn = 0;
    clk(3);
    push_st(11, 4'hF, 5'h01, 0, 0);
    clk(2);
    tck(0, 0);
    tck(0, 0);
    status(12, 4'hF, 5'h01, 0, 0);
    jtag_TRSTn = 1;
    clk(4);
    status(13, 4'hF, 5'h01, 0, 0);
    tck(0, 0);
    status(14, 4'hC, 5'h01, 0, 0);
    to_sdr;
    shift(32'h0, IDC, 5, 0);
    reset = 1;
    push_st(15, 4'hF, 5'h01, 0, 1);
    clk(3);
    status(16, 4'hF, 5'h01, 0, 1);
    reset = 0;
    clk(4);
    status(17, 4'hF, 5'h01, 0, 1);
    tck(0, 0);
    status(18, 4'hC, 5'h01, 0, 0);
    done = 1;
    clk(5);
    $display("FAIL monitor_stalled actual=running required=finished");
    $fatal(1);
  end
endmodule
